// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel array readout sequencer.
package pixel_pkg;

  localparam int PIX_W   = 8;
  localparam int NUM_PIX = 4;
  localparam int IDX_W   = 2;
  localparam int CNT_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_EXPOSE,
    ST_CONVERT,
    ST_TURN,
    ST_READ,
    ST_HOLD,
    ST_DONE
  } state_t;

  function automatic logic is_last_pix(input logic [IDX_W-1:0] idx);
    return idx == IDX_W'(NUM_PIX - 1);
  endfunction

endpackage

// File: rtl/pixel_bus_driver.sv
// Owns the shared pixel bus: tristate drive of the ramp code and the
// registered sample of whatever a pixel puts on the bus.
module pixel_bus_driver
  import pixel_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             oe,
  input  logic [PIX_W-1:0] drive_data,
  input  logic             capture,
  output logic [PIX_W-1:0] sample,
  inout  wire  [PIX_W-1:0] pixData
);

  logic [PIX_W-1:0] sample_reg;

  // oe comes straight from the state register, so an async reset releases
  // the bus in the same instant it forces the FSM to IDLE.
  genvar gi;
  generate
    for (gi = 0; gi < PIX_W; gi++) begin : g_drive
      assign pixData[gi] = oe ? drive_data[gi] : 1'bz;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_reg <= '0;
    end else if (capture) begin
      sample_reg <= pixData;
    end
  end

  assign sample = sample_reg;

endmodule

// File: rtl/pixel_readout.sv
// Frame sequencer for a small pixel array: erase, expose, ramp conversion
// on the shared bus, then per-pixel readout onto a valid/ready stream.
module pixel_readout
  import pixel_pkg::*;
#(
  parameter int ERASE_CYCLES  = 5,
  parameter int EXPOSE_CYCLES = 255,
  parameter int NUM_PIX       = pixel_pkg::NUM_PIX
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  output logic               busy,
  output logic               erase,
  output logic               expose,
  output logic               convert,
  output logic [NUM_PIX-1:0] read,
  inout  wire  [PIX_W-1:0]   pixData,
  output logic [PIX_W-1:0]   out_data,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               frame_done
);

  localparam logic [CNT_W-1:0] ERASE_LAST  = CNT_W'(ERASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXPOSE_LAST = CNT_W'(EXPOSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CONV_LAST   = '1;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] phase_reg, phase_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [IDX_W-1:0] out_idx_reg;
  logic             capture;
  logic             drive_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      phase_reg   <= '0;
      idx_reg     <= '0;
      out_idx_reg <= '0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      idx_reg   <= idx_next;
      if (capture) begin
        out_idx_reg <= idx_reg;
      end
    end
  end

  // The phase counter is reused: erase/expose length, ramp code, and the
  // two-cycle read window.
  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    idx_next   = idx_reg;
    capture    = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        phase_next = '0;
        if (start) begin
          state_next = ST_ERASE;
        end
      end
      ST_ERASE: begin
        if (phase_reg == ERASE_LAST) begin
          state_next = ST_EXPOSE;
          phase_next = '0;
        end else begin
          phase_next = phase_reg + CNT_W'(1);
        end
      end
      ST_EXPOSE: begin
        if (phase_reg == EXPOSE_LAST) begin
          state_next = ST_CONVERT;
          phase_next = '0;
        end else begin
          phase_next = phase_reg + CNT_W'(1);
        end
      end
      ST_CONVERT: begin
        // Leaving at 255 without incrementing keeps the ramp from wrapping.
        if (phase_reg == CONV_LAST) begin
          state_next = ST_TURN;
        end else begin
          phase_next = phase_reg + CNT_W'(1);
        end
      end
      ST_TURN: begin
        state_next = ST_READ;
        phase_next = '0;
        idx_next   = '0;
      end
      ST_READ: begin
        if (phase_reg[0]) begin
          capture    = 1'b1;
          state_next = ST_HOLD;
          phase_next = '0;
        end else begin
          phase_next = phase_reg + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          if (is_last_pix(idx_reg)) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_READ;
            idx_next   = idx_reg + IDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        phase_next = '0;
      end
      default: begin
        state_next = ST_IDLE;
        phase_next = '0;
      end
    endcase
  end

  assign busy       = (state_reg != ST_IDLE);
  assign erase      = (state_reg == ST_ERASE);
  assign expose     = (state_reg == ST_EXPOSE);
  assign convert    = (state_reg == ST_CONVERT);
  assign out_valid  = (state_reg == ST_HOLD);
  assign frame_done = (state_reg == ST_DONE);
  assign drive_en   = (state_reg == ST_CONVERT);
  assign out_idx    = out_idx_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PIX; gi++) begin : g_read
      assign read[gi] = (state_reg == ST_READ) && (idx_reg == IDX_W'(gi));
    end
  endgenerate

  pixel_bus_driver u_bus (
    .clk        (clk),
    .reset_n    (reset_n),
    .oe         (drive_en),
    .drive_data (phase_reg),
    .capture    (capture),
    .sample     (out_data),
    .pixData    (pixData)
  );

endmodule

// File: doc/pixel_readout.md
# pixel_readout

Digital sequencer that drives a 4-pixel array and reads it back over the shared 8-bit tristate `pixData` bus. It runs one frame per `start`: erase, expose, ramp conversion (controller drives the count onto the bus; each pixel latches it when its comparator trips), then reads each pixel in turn via one-hot `read` strobes. Pixel codes are delivered downstream on a valid/ready stream. It sits between the pixel array and the frame buffer / serial output logic.

## Interface
- `ERASE_CYCLES`, 5: cycles `erase` is held high.
- `EXPOSE_CYCLES`, 255: cycles `expose` is held high.
- `NUM_PIX`, 4: pixels on the bus. Fixed at 4 in this revision.
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin frame. Sampled only in IDLE.
- `busy`  out  1: high in every state except IDLE.
- `erase`  out  1: pixel erase strobe.
- `expose`  out  1: pixel expose strobe.
- `convert`  out  1: ramp/conversion enable.
- `read`  out  4: one-hot pixel output-enable. `read[i]` selects pixel i.
- `pixData`  inout  8: shared bus. Driven by this block only in CONVERT.
- `out_data`  out  8: captured pixel code.
- `out_idx`  out  2: pixel index of `out_data`.
- `out_valid`  out  1: `out_data`/`out_idx` valid.
- `out_ready`  in  1: downstream accept.
- `frame_done`  out  1: one-cycle pulse after the last pixel is accepted.

## Operation
- States: IDLE, ERASE, EXPOSE, CONVERT, TURN, READ, HOLD, DONE.
- IDLE: all strobes low, bus released. `start`=1 → ERASE.
- ERASE: `erase`=1 for ERASE_CYCLES cycles → EXPOSE.
- EXPOSE: `expose`=1 for EXPOSE_CYCLES cycles → CONVERT.
- CONVERT:
  - `convert`=1. 8-bit binary counter starts at 0 on entry and increments each cycle.
  - `pixData` = count for 256 cycles (0..255). After value 255 → TURN.
  - No wrap: the counter saturates on exit.
- TURN: one cycle, bus released, no strobe → READ with idx=0.
- READ:
  - `read[idx]`=1 for 2 cycles. The bus is sampled on the second edge into `out_data`, and `out_idx`=idx.
  - → HOLD.
- HOLD:
  - `read`=0, `out_valid`=1.
  - On `out_valid && out_ready`: if idx==3 → DONE, else idx++ and → READ.
- DONE: `frame_done`=1 for one cycle → IDLE.
- Exclusivity:
  - At most one of `erase`/`expose`/`convert`/`read` is active in any cycle.
  - `read` is never nonzero while the block drives `pixData`.
- `start` outside IDLE is ignored. `start` held high causes back-to-back frames, each re-sampled in IDLE.
- `out_data`/`out_idx` are stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE. All strobes 0, `read`=0.
  - `pixData` released to Z.
  - `out_valid`=0, `out_data`=0, `out_idx`=0, `busy`=0, `frame_done`=0.
  - Counter=0.
- Reset mid-frame (including mid-CONVERT): the bus is released in the same instant. No partial output is presented after release.
- Start cycle s (start sampled): `erase` high from cycle s+1 through s+ERASE_CYCLES. `expose` follows immediately with no gap.
- CONVERT spans 256 cycles, then TURN 1 cycle, then READ 2 cycles.
- First `out_valid` appears at s+1+ERASE_CYCLES+EXPOSE_CYCLES+256+1+2.
- Per-pixel cost is 3 cycles plus any `out_ready` stall.
- `out_ready` high before `out_valid` is legal. The handshake completes in the first cycle both are high.
- `frame_done` is asserted the cycle after the idx-3 handshake, and `busy` drops the following cycle.

## Structure
- Shared package `pixel_pkg`:
  - State enum.
  - `PIX_W`=8.
  - `NUM_PIX`=4.
  - Counter width.
- Sub-module `pixel_bus_driver`: owns the 8-bit tristate driver (`oe` + data → `pixData`) and the input sample register. It keeps the bus-drive rule in one place.
- Top-level holds the FSM, the phase counter (shared between erase/expose/convert) and the pixel index.

## Test plan
- Bench parameters: ERASE_CYCLES=3, EXPOSE_CYCLES=4. Four `PIXEL_SENSOR` models with differing light levels, plus a bus-contention checker (X on `pixData` = fail).
- Frame, `out_ready` tied 1:
  - `start` pulse → `erase` 3 cycles, then `expose` 4 cycles, then `convert` 256 cycles.
  - Four outputs with idx 0,1,2,3 matching each pixel model's latched code.
  - `frame_done` pulses once, at the expected cycle.
- Backpressure: `out_ready` low for 10 cycles on idx 1 → `out_valid` held, data stable, `read` low, no idx skip.
- Bus ownership: assertion checks that `pixData` is Z outside CONVERT, that it equals 0..255 sequentially in CONVERT, and that there is never a `read` overlap.
- Reset mid-CONVERT at count 100:
  - All outputs return to reset values and the bus is Z immediately.
  - The next `start` runs a clean frame with the counter starting at 0.
- `start` pulses during EXPOSE and HOLD → ignored; exactly one `frame_done`.
- `start` held high → two consecutive frames with exactly one IDLE cycle between them.
